// File: rtl/per_rr_arbiter_if.sv
// Shared peripheral port of the round-robin arbiter: request channel out, in-order response channel in.
// The arbiter connects through the master modport and the peripheral through the slave modport.
interface per_rr_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

    logic                  per_req_o;
    logic [ADDR_WIDTH-1:0] per_add_o;
    logic                  per_we_n_o;
    logic [DATA_WIDTH-1:0] per_wdata_o;
    logic [BE_WIDTH-1:0]   per_be_o;
    logic                  per_gnt_i;
    logic                  per_r_valid_i;
    logic                  per_r_opc_i;
    logic [DATA_WIDTH-1:0] per_r_rdata_i;

    modport master (
        output per_req_o, per_add_o, per_we_n_o, per_wdata_o, per_be_o,
        input  per_gnt_i, per_r_valid_i, per_r_opc_i, per_r_rdata_i
    );

    modport slave (
        input  per_req_o, per_add_o, per_we_n_o, per_wdata_o, per_be_o,
        output per_gnt_i, per_r_valid_i, per_r_opc_i, per_r_rdata_i
    );
endinterface

// File: rtl/per_rr_arbiter.sv
// Round-robin arbiter sharing one peripheral port among N_MASTERS requesters, with a
// selection lock while ungranted and an outstanding-request FIFO that routes in-order responses.
module per_rr_arbiter #(
    parameter int unsigned N_MASTERS       = 2,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MAX_OUTSTANDING = 2,
    localparam int unsigned BE_WIDTH       = DATA_WIDTH / 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [N_MASTERS-1:0]            m_req_i,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_add_i,
    input  logic [N_MASTERS-1:0]            m_we_n_i,
    input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [N_MASTERS*BE_WIDTH-1:0]   m_be_i,
    output logic [N_MASTERS-1:0]            m_gnt_o,
    output logic [N_MASTERS-1:0]            m_r_valid_o,
    output logic                            m_r_opc_o,
    output logic [DATA_WIDTH-1:0]           m_r_rdata_o,
    per_rr_arbiter_if.master                per_bus,
    output logic                            busy_o,
    output logic                            err_o
);
    localparam int unsigned IDX_W = $clog2(N_MASTERS);
    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    typedef enum logic {ST_FREE, ST_LOCKED} lock_state_e;

    lock_state_e      state_q, state_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [IDX_W-1:0] rr_idx, sel_idx, head_idx;
    logic             rr_found, sel_valid, per_req, hs, pop;

    // Round-robin search: first asserted request at or after ptr_q, wrapping.
    always_comb begin
        int unsigned cand;
        rr_idx   = ptr_q;
        rr_found = 1'b0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            cand = 32'(ptr_q) + i;
            if (cand >= N_MASTERS) cand = cand - N_MASTERS;
            if (!rr_found && m_req_i[cand]) begin
                rr_idx   = IDX_W'(cand);
                rr_found = 1'b1;
            end
        end
    end

    // A locked selection stays presented even if its master drops the request.
    assign sel_idx   = (state_q == ST_LOCKED) ? lock_idx_q : rr_idx;
    assign sel_valid = (state_q == ST_LOCKED) | rr_found;
    assign per_req   = sel_valid && (cnt_q < CNT_W'(MAX_OUTSTANDING));
    assign hs        = per_req & per_bus.per_gnt_i;
    assign pop       = per_bus.per_r_valid_i && (cnt_q != '0);
    assign head_idx  = fifo_q[rd_q];

    assign per_bus.per_req_o   = per_req;
    assign per_bus.per_add_o   = m_add_i[sel_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign per_bus.per_we_n_o  = m_we_n_i[sel_idx];
    assign per_bus.per_wdata_o = m_wdata_i[sel_idx*DATA_WIDTH +: DATA_WIDTH];
    assign per_bus.per_be_o    = m_be_i[sel_idx*BE_WIDTH +: BE_WIDTH];

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        for (int unsigned k = 0; k < N_MASTERS; k++) begin
            m_gnt_o[k]     = hs && (sel_idx == IDX_W'(k));
            m_r_valid_o[k] = pop && (head_idx == IDX_W'(k));
        end
    end

    assign m_r_opc_o   = per_bus.per_r_opc_i;
    assign m_r_rdata_o = per_bus.per_r_rdata_i;
    assign busy_o      = (cnt_q != '0) | per_req;
    assign err_o       = err_q;

    always_comb begin
        state_d    = (per_req && !per_bus.per_gnt_i) ? ST_LOCKED : ST_FREE;
        lock_idx_d = sel_idx;
        ptr_d      = ptr_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        cnt_d      = cnt_q;
        err_d      = err_q | (per_bus.per_r_valid_i && (cnt_q == '0));
        if (hs) begin
            ptr_d = (sel_idx == IDX_W'(N_MASTERS - 1)) ? '0 : sel_idx + 1'b1;
            wr_d  = (wr_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = (rd_q == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : rd_q + 1'b1;
        end
        if (hs && !pop) cnt_d = cnt_q + 1'b1;
        else if (pop && !hs) cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_FREE;
            lock_idx_q <= '0;
            ptr_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
            ptr_q      <= ptr_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    // FIFO storage needs no reset; entries are only read while cnt_q is nonzero.
    always_ff @(posedge clk_i) begin
        if (hs) fifo_q[wr_q] <= sel_idx;
    end
endmodule

// File: tb/tb_per_rr_arbiter.sv
// Directed-vector bench for per_rr_arbiter (N_MASTERS=2, MAX_OUTSTANDING=2) with hand-computed
// expectations for arbitration, lock, outstanding limit, response routing and error flag.
module tb_per_rr_arbiter;
    localparam int unsigned NM = 2;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;
    localparam int unsigned MO = 2;

    localparam logic [AW-1:0] ADDR0 = 32'hA000_0000;
    localparam logic [AW-1:0] ADDR1 = 32'hB000_0004;
    localparam logic [DW-1:0] WD0   = 32'h1111_0000;
    localparam logic [DW-1:0] WD1   = 32'h2222_0001;

    logic             clk = 1'b0;
    logic             rst;
    logic [NM-1:0]    m_req;
    logic [NM*AW-1:0] m_add;
    logic [NM-1:0]    m_we_n;
    logic [NM*DW-1:0] m_wdata;
    logic [NM*BW-1:0] m_be;
    logic [NM-1:0]    m_gnt;
    logic [NM-1:0]    m_r_valid;
    logic             m_r_opc;
    logic [DW-1:0]    m_r_rdata;
    logic             busy;
    logic             err;

    int unsigned n_vec = 0;
    int unsigned n_miscmp = 0;

    per_rr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) per_bus ();

    per_rr_arbiter #(
        .N_MASTERS(NM),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .m_req_i(m_req),
        .m_add_i(m_add),
        .m_we_n_i(m_we_n),
        .m_wdata_i(m_wdata),
        .m_be_i(m_be),
        .m_gnt_o(m_gnt),
        .m_r_valid_o(m_r_valid),
        .m_r_opc_o(m_r_opc),
        .m_r_rdata_o(m_r_rdata),
        .per_bus(per_bus),
        .busy_o(busy),
        .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; checks happen 1ns later, far from either edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [NM-1:0] req, input logic gnt, input logic rv);
        m_req                 = req;
        per_bus.per_gnt_i     = gnt;
        per_bus.per_r_valid_i = rv;
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        m_add   = {ADDR1, ADDR0};
        m_we_n  = 2'b01;
        m_wdata = {WD1, WD0};
        m_be    = {4'hC, 4'h3};
        per_bus.per_r_opc_i   = 1'b1;
        per_bus.per_r_rdata_i = 32'hDEAD_BEEF;
        drive(2'b00, 1'b0, 1'b0);
        step();
        step();

        // Outputs quiet during reset
        drive(2'b00, 1'b0, 1'b0);
        check("rst_per_req", 64'(per_bus.per_req_o), 64'd0);
        check("rst_gnt", 64'(m_gnt), 64'd0);
        check("rst_rvalid", 64'(m_r_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        rst = 1'b0;
        step();

        // Both requesting, grant always high: alternation with overlapping responses
        drive(2'b11, 1'b1, 1'b0);
        check("rr1_gnt", 64'(m_gnt), 64'h1);
        check("rr1_add", 64'(per_bus.per_add_o), 64'(ADDR0));
        check("rr1_wdata", 64'(per_bus.per_wdata_o), 64'(WD0));
        check("rr1_be", 64'(per_bus.per_be_o), 64'h3);
        check("rr1_we_n", 64'(per_bus.per_we_n_o), 64'd1);
        step();
        drive(2'b11, 1'b1, 1'b1);
        check("rr2_gnt", 64'(m_gnt), 64'h2);
        check("rr2_add", 64'(per_bus.per_add_o), 64'(ADDR1));
        check("rr2_we_n", 64'(per_bus.per_we_n_o), 64'd0);
        check("rr2_rvalid", 64'(m_r_valid), 64'h1);
        check("rr2_rdata", 64'(m_r_rdata), 64'hDEAD_BEEF);
        check("rr2_opc", 64'(m_r_opc), 64'd1);
        step();
        check("rr3_gnt", 64'(m_gnt), 64'h1);
        check("rr3_rvalid", 64'(m_r_valid), 64'h2);
        step();
        check("rr4_gnt", 64'(m_gnt), 64'h2);
        check("rr4_rvalid", 64'(m_r_valid), 64'h1);
        step();
        drive(2'b00, 1'b0, 1'b1);
        check("drain_rvalid", 64'(m_r_valid), 64'h2);
        check("drain_per_req", 64'(per_bus.per_req_o), 64'd0);
        check("drain_busy", 64'(busy), 64'd1);
        step();
        drive(2'b00, 1'b0, 1'b0);
        check("idle_busy", 64'(busy), 64'd0);

        // Only m1 requesting with ptr at 0: search wraps past idle m0
        drive(2'b10, 1'b1, 1'b0);
        check("wrap_gnt", 64'(m_gnt), 64'h2);
        check("wrap_be", 64'(per_bus.per_be_o), 64'hC);
        step();
        drive(2'b00, 1'b0, 1'b1);
        check("wrap_rvalid", 64'(m_r_valid), 64'h2);
        step();

        // Lock: m0 presented ungranted, m1 joins, selection must not move
        drive(2'b01, 1'b0, 1'b0);
        check("lock0_per_req", 64'(per_bus.per_req_o), 64'd1);
        check("lock0_gnt", 64'(m_gnt), 64'h0);
        check("lock0_add", 64'(per_bus.per_add_o), 64'(ADDR0));
        step();
        drive(2'b11, 1'b0, 1'b0);
        check("lock1_add", 64'(per_bus.per_add_o), 64'(ADDR0));
        step();
        check("lock2_add", 64'(per_bus.per_add_o), 64'(ADDR0));
        step();
        drive(2'b11, 1'b1, 1'b0);
        check("lock3_gnt", 64'(m_gnt), 64'h1);
        check("lock3_add", 64'(per_bus.per_add_o), 64'(ADDR0));
        step();
        check("after_lock_gnt", 64'(m_gnt), 64'h2);
        step();

        // Two outstanding: requests blocked even with a pop in the same cycle
        check("full_per_req", 64'(per_bus.per_req_o), 64'd0);
        check("full_gnt", 64'(m_gnt), 64'h0);
        check("full_busy", 64'(busy), 64'd1);
        drive(2'b11, 1'b1, 1'b1);
        check("full_pop_rvalid", 64'(m_r_valid), 64'h1);
        check("full_pop_per_req", 64'(per_bus.per_req_o), 64'd0);
        step();
        drive(2'b11, 1'b0, 1'b0);
        check("resume_per_req", 64'(per_bus.per_req_o), 64'd1);
        check("resume_add", 64'(per_bus.per_add_o), 64'(ADDR0));
        step();

        // Reset mid-transaction with one outstanding entry and a held lock
        rst = 1'b1;
        drive(2'b00, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(2'b00, 1'b0, 1'b0);
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_per_req", 64'(per_bus.per_req_o), 64'd0);
        drive(2'b11, 1'b1, 1'b0);
        check("post_rst_ptr_gnt", 64'(m_gnt), 64'h1);
        step();
        drive(2'b00, 1'b0, 1'b1);
        check("post_rst_rvalid", 64'(m_r_valid), 64'h1);
        step();

        // Stray response with nothing outstanding
        drive(2'b00, 1'b0, 1'b1);
        check("stray_rvalid", 64'(m_r_valid), 64'h0);
        check("stray_err_same", 64'(err), 64'd0);
        step();
        drive(2'b00, 1'b0, 1'b0);
        check("stray_err_set", 64'(err), 64'd1);
        check("stray_busy", 64'(busy), 64'd0);
        step();
        check("stray_err_held", 64'(err), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("err_cleared", 64'(err), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule

// File: doc/per_rr_arbiter.md
PER_RR_ARBITER -- requirements
Module: per_rr_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 2, number of requesters sharing one peripheral port (legal 2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, peripheral address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, peripheral data width; BE_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, granted-but-unanswered request limit (legal 1..8).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-008 SHALL have ports m_req_i  input  N_MASTERS; m_add_i  input  N_MASTERS*ADDR_WIDTH; m_we_n_i  input  N_MASTERS; m_wdata_i  input  N_MASTERS*DATA_WIDTH; m_be_i  input  N_MASTERS*BE_WIDTH: per-master request fields, master k in slice k.
REQ-009 SHALL have ports m_gnt_o  output  N_MASTERS; m_r_valid_o  output  N_MASTERS; m_r_opc_o  output  1; m_r_rdata_o  output  DATA_WIDTH: per-master grant and response.
REQ-010 SHALL have ports per_req_o  output  1; per_add_o  output  ADDR_WIDTH; per_we_n_o  output  1; per_wdata_o  output  DATA_WIDTH; per_be_o  output  BE_WIDTH; per_gnt_i  input  1: shared peripheral request channel.
REQ-011 SHALL have ports per_r_valid_i  input  1; per_r_opc_i  input  1; per_r_rdata_i  input  DATA_WIDTH: shared peripheral response channel, in order.
REQ-012 SHALL have ports busy_o  output  1  requests in flight; err_o  output  1  sticky protocol error.

Function
REQ-013 Arbitration SHALL be round-robin: among asserted m_req_i, select the first index at or after pointer ptr, wrapping modulo N_MASTERS.
REQ-014 ptr SHALL reset to 0 and, on each peripheral handshake (per_req_o & per_gnt_i) for master k, become (k+1) mod N_MASTERS next cycle.
REQ-015 Lock: while per_req_o=1 and per_gnt_i=0, the selected index SHALL be registered and held unchanged until handshake, regardless of other m_req_i.
REQ-016 per_req_o SHALL equal (any selected m_req_i) & (count < MAX_OUTSTANDING); per_add/we_n/wdata/be SHALL mirror the selected master combinationally.
REQ-017 m_gnt_o[k] SHALL be per_gnt_i & per_req_o & (selected==k); at most one bit set; no grant when per_req_o=0.
REQ-018 Outstanding FIFO (depth MAX_OUTSTANDING, entry = master index) SHALL push on handshake and pop on per_r_valid_i; count SHALL be $clog2(MAX_OUTSTANDING+1) bits.
REQ-019 Simultaneous push and pop SHALL leave count unchanged and pop the head entry before the new entry becomes head; read/write pointers wrap modulo MAX_OUTSTANDING.
REQ-020 When count==MAX_OUTSTANDING, per_req_o SHALL be 0 even if a pop occurs that cycle (no bypass); requests resume the cycle after count drops.
REQ-021 m_r_valid_o[head] SHALL equal per_r_valid_i (same cycle); all other bits 0; m_r_opc_o/m_r_rdata_o SHALL be per_r_opc_i/per_r_rdata_i broadcast.
REQ-022 per_r_valid_i with count==0 SHALL be dropped (no m_r_valid_o), count unchanged, err_o set to 1 and held until reset.
REQ-023 busy_o SHALL be (count != 0) | per_req_o.
REQ-024 A master dropping m_req_i while locked and ungranted SHALL still be presented; masters are required to hold requests until grant.

Reset
REQ-025 With rst_i=1 at a clock edge: ptr=0, lock cleared, FIFO emptied, count=0, err_o=0.
REQ-026 During and after reset, with m_req_i=0: per_req_o, m_gnt_o, m_r_valid_o, busy_o, err_o SHALL be 0; data outputs don't-care.
REQ-027 Reset mid-transaction SHALL discard outstanding entries; responses arriving after reset with count==0 SHALL follow REQ-022.

Verification
REQ-028 N=2, m_req_i=11, per_gnt_i=1 constant -> grants alternate m0,m1,m0,m1; ptr 0,1,0,1.
REQ-029 m_req_i=01, per_gnt_i=0 for 3 cycles, m_req_i becomes 11 at cycle 1 -> per_add_o stays m0 address, m_gnt_o=01 when per_gnt_i rises.
REQ-030 MAX_OUTSTANDING=2, two grants, no responses -> per_req_o=0, busy_o=1; one per_r_valid_i -> m_r_valid_o routes to first master, per_req_o=1 next cycle.
REQ-031 Grant m1 and per_r_valid_i for earlier m0 request in same cycle -> m_r_valid_o=01, count unchanged at 1, next response routes to m1.
REQ-032 per_r_valid_i=1 with count=0 -> m_r_valid_o=00, err_o=1 held; rst_i=1 -> err_o=0.
REQ-033 rst_i=1 with count=2 -> next cycle count=0, busy_o=0, ptr=0.
